// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller.
//   fnd_state_e : scan sequencer states (IDLE / BLANK / DRIVE)
//   FONT_BLANK  : all segments off (active-low)
//   COM_OFF     : all digit commons off (active-low)
//   NUM_DIGITS  : number of scanned digits
//   SEG_TABLE   : hex nibble -> 7-bit active-low segments {g,f,e,d,c,b,a}
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } fnd_state_e;

  localparam logic [7:0]  FONT_BLANK = 8'hFF;
  localparam logic [3:0]  COM_OFF    = 4'hF;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational hex-to-segment decoder.
//   i_value : 4-bit nibble to display
//   o_seg   : active-low segments {g,f,e,d,c,b,a}
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_TABLE[i_value];
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan sequencer for a 4-digit common-anode FND.
// Each digit slot is SCAN_DIV cycles: BLANK_CYCLES of dead time with all
// commons off, then the selected common is driven for the rest of the slot.
// Optional macro FND_DP_EN adds the i_dp port and drives the decimal point.
//   i_clk        : system clock
//   i_reset_n    : asynchronous reset, active-low
//   i_enable     : 1 = scan, 0 = display dark
//   i_digit_en   : per-digit enable mask (bit 0 = ones)
//   i_mux_value  : nibble returned by the external mux for o_sel
//   i_dp         : per-digit decimal point, 1 = lit (FND_DP_EN only)
//   o_sel        : digit select to the external mux
//   o_fnd_com    : digit commons, active-low
//   o_fnd_font   : segments {dp,g,f,e,d,c,b,a}, active-low
//   o_frame_tick : one-cycle pulse on the 3 -> 0 select wrap
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [3:0] i_digit_en,
  input  logic [3:0] i_mux_value,
`ifdef FND_DP_EN
  input  logic [3:0] i_dp,
`endif
  output logic [1:0] o_sel,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_font,
  output logic       o_frame_tick
);

  localparam int unsigned   CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);

  fnd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    font_q, font_d;
  logic          tick_q, tick_d;
  logic [6:0]    seg;
  logic          dp_n;

  fnd_font_decoder u_font_decoder (
    .i_value (i_mux_value),
    .o_seg   (seg)
  );

`ifdef FND_DP_EN
  always_comb begin
    dp_n = ~i_dp[sel_q];
  end
`else
  always_comb begin
    dp_n = 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        sel_d = '0;
        if (i_enable) state_d = BLANK;
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
          tick_d  = (sel_q == 2'd3);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = '0;
      end
    endcase

    // Disable overrides everything, including a slot boundary in the same cycle.
    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      tick_d  = 1'b0;
    end

    // Font is registered from the mux return of the current select, so it lags
    // o_sel by one cycle; the blank window hides that lag.
    font_d = (state_d == IDLE) ? FONT_BLANK : {dp_n, seg};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      font_q  <= FONT_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      font_q  <= font_d;
      tick_q  <= tick_d;
    end
  end

  // Commons follow the digit mask combinationally so mask edits act immediately.
  always_comb begin
    o_fnd_com = COM_OFF;
    if (state_q == DRIVE) o_fnd_com[sel_q] = ~i_digit_en[sel_q];
  end

  assign o_sel        = sel_q;
  assign o_fnd_font   = font_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

  localparam int SCAN  = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = 4 * SCAN;

  localparam logic [7:0] FONT_REF [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [3:0] i_digit_en = 4'hF;
  logic [3:0] i_mux_value;
`ifdef FND_DP_EN
  logic [3:0] i_dp = 4'h0;
`endif
  logic [1:0] o_sel;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;
  logic       o_frame_tick;

  logic [3:0] digits [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  // External 4:1 nibble mux
  assign i_mux_value = digits[o_sel];

  fnd_scan_controller #(
    .SCAN_DIV     (SCAN),
    .BLANK_CYCLES (BLNK)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_enable     (i_enable),
    .i_digit_en   (i_digit_en),
    .i_mux_value  (i_mux_value),
`ifdef FND_DP_EN
    .i_dp         (i_dp),
`endif
    .o_sel        (o_sel),
    .o_fnd_com    (o_fnd_com),
    .o_fnd_font   (o_fnd_font),
    .o_frame_tick (o_frame_tick)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan since leaving the dark state.
  bit         m_run  = 1'b0;
  int         m_pos  = 0;
  logic [1:0] m_sel  = 2'd0;
  logic [7:0] m_font = 8'hFF;
  logic [7:0] raw;
  logic [3:0] e_com;
  logic       e_tick;
  int         slot, phase;

  always @(posedge i_clk) begin
    // Font captured at this edge: decode of what the mux presented for the old select.
`ifdef FND_DP_EN
    raw = {~i_dp[m_sel], FONT_REF[digits[m_sel]][6:0]};
`else
    raw = {1'b1, FONT_REF[digits[m_sel]][6:0]};
`endif
    if (!i_reset_n || !i_enable) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_font = 8'hFF;
    end else begin
      if (m_run) m_pos++;
      else begin
        m_run = 1'b1;
        m_pos = 0;
      end
      m_font = raw;
    end
    slot  = m_run ? (m_pos / SCAN) % 4 : 0;
    phase = m_pos % SCAN;
    m_sel = 2'(slot);
    #1;
    e_com = 4'hF;
    if (m_run && phase >= BLNK) e_com[slot] = ~i_digit_en[slot];
    e_tick = m_run && (m_pos > 0) && (m_pos % FRAME == 0);
    chk("sel",  o_sel,        m_sel);
    chk("com",  o_fnd_com,    e_com);
    chk("font", o_fnd_font,   m_font);
    chk("tick", o_frame_tick, e_tick);
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_com"},  o_fnd_com,    4'hF);
    chk({tag, "_font"}, o_fnd_font,   8'hFF);
    chk({tag, "_sel"},  o_sel,        2'd0);
    chk({tag, "_tick"}, o_frame_tick, 1'b0);
  endtask

  int bad, low1, low3, ticks, dp_low, r;

  initial begin
    // 1: reset with random inputs, then release while disabled
    repeat (4) begin
      @(negedge i_clk);
      i_enable   = 1'($urandom);
      i_digit_en = 4'($urandom);
      for (int unsigned k = 0; k < 4; k++) digits[k] = 4'($urandom);
      chk_reset_vals("rst_hold");
    end
    i_enable  = 1'b0;
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk_reset_vals("rst_release");

    // 2: scan digits 1,2,3,4
    digits     = '{4'd1, 4'd2, 4'd3, 4'd4};
    i_digit_en = 4'hF;
    i_enable   = 1'b1;
    repeat (3) @(negedge i_clk);  // pos 2
    chk("scan_d0_com", o_fnd_com, 4'hE);  chk("scan_d0_font", o_fnd_font, 8'hF9);
    repeat (SCAN) @(negedge i_clk);  // pos 10
    chk("scan_d1_com", o_fnd_com, 4'hD);  chk("scan_d1_font", o_fnd_font, 8'hA4);
    chk("scan_d1_sel", o_sel, 2'd1);
    repeat (SCAN) @(negedge i_clk);  // pos 18
    chk("scan_d2_com", o_fnd_com, 4'hB);  chk("scan_d2_font", o_fnd_font, 8'hB0);
    repeat (SCAN) @(negedge i_clk);  // pos 26
    chk("scan_d3_com", o_fnd_com, 4'h7);  chk("scan_d3_font", o_fnd_font, 8'h99);
    repeat (6) @(negedge i_clk);     // pos 32
    chk("wrap_tick", o_frame_tick, 1'b1);
    chk("wrap_sel",  o_sel, 2'd0);
    chk("wrap_com",  o_fnd_com, 4'hF);

    // 3: mask 1010 for one full frame
    i_digit_en = 4'b1010;
    bad = 0; low1 = 0; low3 = 0;
    repeat (FRAME) begin
      @(negedge i_clk);
      if (!o_fnd_com[0] || !o_fnd_com[2]) bad++;
      if (!o_fnd_com[1]) low1++;
      if (!o_fnd_com[3]) low3++;
    end
    chk("mask_masked_low", bad, 0);
    chk("mask_com1_cycles", low1, SCAN - BLNK);
    chk("mask_com3_cycles", low3, SCAN - BLNK);

    // 4: disable mid-DRIVE of digit 2, then re-enable
    i_digit_en = 4'hF;
    repeat (20) @(negedge i_clk);  // pos 84: digit 2, phase 4
    chk("dis_pre_sel", o_sel, 2'd2);
    chk("dis_pre_com", o_fnd_com, 4'hB);
    i_enable = 1'b0;
    @(negedge i_clk);
    chk_reset_vals("dis");
    repeat (3) @(negedge i_clk);
    i_enable = 1'b1;
    @(negedge i_clk);
    chk("reen_blank0", o_fnd_com, 4'hF);
    @(negedge i_clk);
    chk("reen_blank1", o_fnd_com, 4'hF);
    @(negedge i_clk);
    chk("reen_drive_com", o_fnd_com, 4'hE);
    chk("reen_drive_sel", o_sel, 2'd0);

    // 5: four frames of ticks, none while disabled
    ticks = 0;
    repeat (4 * FRAME) begin
      @(negedge i_clk);
      if (o_frame_tick) ticks++;
    end
    chk("tick_count_4frames", ticks, 4);
    i_enable = 1'b0;
    ticks = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_frame_tick) ticks++;
    end
    chk("tick_count_disabled", ticks, 0);

    // 6: decimal point
    dp_low = 0;
`ifdef FND_DP_EN
    i_dp = 4'b0100;
`endif
    i_enable = 1'b1;
    repeat (FRAME + 1) begin
      @(negedge i_clk);
      if (!o_fnd_font[7]) dp_low++;
    end
`ifdef FND_DP_EN
    chk("dp_low_cycles", dp_low, 8);
    i_dp = 4'h0;
`else
    chk("dp_low_cycles", dp_low, 0);
`endif

    // Asynchronous reset mid-slot
    i_enable = 1'b0;
    @(negedge i_clk);
    i_enable = 1'b1;
    repeat (21) @(negedge i_clk);  // pos 20
    chk("arst_pre_com", o_fnd_com, 4'hB);
    #2 i_reset_n = 1'b0;
    #1 chk_reset_vals("arst");
    repeat (2) @(negedge i_clk);
    #2 i_reset_n = 1'b1;

    // Random phase
    repeat (2000) begin
      @(negedge i_clk);
      r = int'($urandom_range(0, 999));
      if (i_enable) begin
        if (r < 20) i_enable = 1'b0;
      end else if (r < 200) i_enable = 1'b1;
      if ($urandom_range(0, 15) == 0) i_digit_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) digits[$urandom_range(0, 3)] = 4'($urandom);
`ifdef FND_DP_EN
      if ($urandom_range(0, 7) == 0) i_dp = 4'($urandom);
`endif
      if ($urandom_range(0, 299) == 0) begin
        #2 i_reset_n = 1'b0;
        #1 chk_reset_vals("rand_arst");
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
      end
    end

    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
